mvu_job_dispatcher: RTL and testbench
=====================================

MVU_JOB_DISPATCHER -- requirements
Module: mvu_job_dispatcher

Interface
REQ-001 SHALL have parameter NUM_MVU, default 8, the number of MVU slices and pito harts.
REQ-002 SHALL have parameter DEPTH, default 4, the job queue depth in entries; power of two.
REQ-003 SHALL have parameter DESC_W, default 64, the opaque job descriptor width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_valid, input, 1 bit: the pito CSR side offers a job.
REQ-007 SHALL have port cmd_ready, output, 1 bit: the queue can accept a job.
REQ-008 SHALL have port cmd_mvu, input, $clog2(NUM_MVU) bits: the target MVU index.
REQ-009 SHALL have port cmd_desc, input, DESC_W bits: the job descriptor.
REQ-010 SHALL have port mvu_start, output, NUM_MVU bits: one-hot, single-cycle start pulse.
REQ-011 SHALL have port mvu_desc, output, DESC_W bits: the descriptor, valid only while mvu_start is nonzero.
REQ-012 SHALL have port mvu_done, input, NUM_MVU bits: per-MVU single-cycle completion pulse.
REQ-013 SHALL have port mvu_irq, output, NUM_MVU bits: per-hart sticky completion interrupt.
REQ-014 SHALL have port irq_clr, input, NUM_MVU bits: per-hart interrupt clear.
REQ-015 SHALL have port busy, output, NUM_MVU bits: the MVU has a job outstanding.
REQ-016 SHALL have port q_count, output, $clog2(DEPTH)+1 bits: the queue occupancy.
REQ-017 SHALL have port err, output, 1 bit: sticky flag for a spurious done.

Function
REQ-018 SHALL accept a job when cmd_valid and cmd_ready are both 1 at a rising edge; cmd_ready SHALL equal (q_count < DEPTH) and SHALL NOT depend on a same-cycle pop.
REQ-019 SHALL hold accepted jobs in order; dispatch SHALL be strictly in order, so a head job whose target is busy blocks all later jobs.
REQ-020 SHALL run a dispatch FSM with two states, IDLE and ISSUE.
REQ-021 In IDLE, SHALL go to ISSUE when q_count>0 and busy[head.mvu]==0; otherwise SHALL stay in IDLE.
REQ-022 In ISSUE, SHALL drive mvu_start[head.mvu]=1 and mvu_desc=head.desc for exactly one cycle, pop the head, set busy[head.mvu], and return to IDLE.
REQ-023 Latency: a job accepted at edge N SHALL produce mvu_start during cycle N+2 at the earliest; there is no bypass path.
REQ-024 Peak throughput SHALL be one dispatch per 2 cycles.
REQ-025 A push and a pop in the same cycle SHALL leave q_count unchanged.
REQ-026 Queue pointers SHALL wrap modulo DEPTH.
REQ-027 A mvu_done[i] pulse with busy[i]==1 SHALL clear busy[i] and set mvu_irq[i] at the following edge.
REQ-028 A mvu_done[i] pulse with busy[i]==0 SHALL set err and SHALL change neither busy nor mvu_irq.
REQ-029 irq_clr[i] SHALL clear mvu_irq[i]; if set and clear occur in the same cycle, set SHALL win.
REQ-030 A new job to MVU i SHALL be able to issue in the cycle after busy[i] clears, i.e. at the earliest 2 cycles after the mvu_done pulse.
REQ-031 mvu_done bits for different MVUs SHALL be handled independently and simultaneously.
REQ-032 mvu_start SHALL be 0 and mvu_desc SHALL be 0 outside ISSUE.
REQ-033 err SHALL clear only on reset.

Reset
REQ-034 On rst asserted, the block SHALL asynchronously force FSM=IDLE, queue empty, q_count=0, cmd_ready=0, busy=0, mvu_irq=0, mvu_start=0, mvu_desc=0, err=0.
REQ-035 cmd_ready SHALL rise in the first cycle after rst deasserts.
REQ-036 Reset asserted mid-ISSUE SHALL drop mvu_start immediately and discard all queued jobs.

Structure
REQ-037 NUM_MVU, DESC_W and typedef mvu_job_t (mvu index plus descriptor) SHALL reside in the shared package accel_pkg.
REQ-038 Queue storage SHALL be a sub-module job_fifo with parameters DEPTH and data type mvu_job_t, using the same clk/rst.
REQ-039 The FSM, busy/irq/err tracking and the output registers SHALL reside in mvu_job_dispatcher.

Verification
REQ-040 Push a job (mvu=3, desc=0xA5) at edge 10 -> mvu_start=0x08 and mvu_desc=0xA5 in cycle 12; busy[3]=1 from cycle 13.
REQ-041 Push 5 jobs back-to-back, all to distinct MVUs 0..4, with no pops -> cmd_ready=0 after 4 accepts while the queue is full; starts appear in order at a 2-cycle spacing.
REQ-042 Queue jobs to MVU 2, MVU 2, MVU 5 -> the second job stalls the MVU 5 job until mvu_done[2]; the second MVU 2 start occurs 2 cycles after the done pulse.
REQ-043 Pulse mvu_done[6] while busy[6]=0 -> err=1 and mvu_irq unchanged; drive mvu_done[1] and irq_clr[1] in the same cycle while busy[1]=1 -> mvu_irq[1]=1.
REQ-044 Assert rst during the ISSUE cycle with 3 jobs queued -> mvu_start=0 immediately, q_count=0, busy=0; no start pulses occur after release.
REQ-045 Run 1000 random push/done cycles -> starts match a scoreboard in order, busy never exceeds one job per MVU, and q_count stays within 0..4.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: MVU count, descriptor width, the job record
// passed from the pito CSR side to the dispatcher, and dispatcher states.
package accel_pkg;

    localparam int NUM_MVU   = 8;
    localparam int DESC_W    = 64;
    localparam int MVU_IDX_W = (NUM_MVU > 1) ? $clog2(NUM_MVU) : 1;

    typedef logic [MVU_IDX_W-1:0] mvu_idx_t;

    typedef struct packed {
        mvu_idx_t          mvu;
        logic [DESC_W-1:0] desc;
    } mvu_job_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } disp_state_t;

    function automatic logic [NUM_MVU-1:0] mvu_onehot(input mvu_idx_t idx);
        mvu_onehot      = '0;
        mvu_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/job_fifo.sv
// In-order job queue of DEPTH entries (power of two, at least 2); pointers wrap
// naturally and occupancy is kept as an explicit count so full/empty are unambiguous.
module job_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = accel_pkg::mvu_job_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  T                       i_push_data,
    input  logic                   i_pop,
    output T                       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != FULL_CNT);
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: which entries are live is decided by the count alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/mvu_job_dispatcher.sv
// MVU job dispatcher: queues jobs from the pito CSR side and issues them strictly
// in order, one start pulse per job, tracking per-MVU busy, interrupts and errors.
module mvu_job_dispatcher #(
    parameter int NUM_MVU = accel_pkg::NUM_MVU,
    parameter int DEPTH   = 4,
    parameter int DESC_W  = accel_pkg::DESC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [$clog2(NUM_MVU)-1:0] cmd_mvu,
    input  logic [DESC_W-1:0]          cmd_desc,
    output logic [NUM_MVU-1:0]         mvu_start,
    output logic [DESC_W-1:0]          mvu_desc,
    input  logic [NUM_MVU-1:0]         mvu_done,
    output logic [NUM_MVU-1:0]         mvu_irq,
    input  logic [NUM_MVU-1:0]         irq_clr,
    output logic [NUM_MVU-1:0]         busy,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       err
);

    import accel_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    disp_state_t        r_state;
    disp_state_t        w_state_next;
    mvu_job_t           w_push_job;
    mvu_job_t           w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_accept;
    logic               w_pop;
    logic               r_live;
    logic [NUM_MVU-1:0] w_head_onehot;
    logic [NUM_MVU-1:0] w_issue_set;
    logic [NUM_MVU-1:0] w_done_ok;
    logic [NUM_MVU-1:0] w_done_bad;
    logic [NUM_MVU-1:0] r_busy;
    logic [NUM_MVU-1:0] r_irq;
    logic [NUM_MVU-1:0] r_start;
    logic [DESC_W-1:0]  r_desc;
    logic               r_err;

    // Ready is held low through reset and rises on the first clock after release.
    assign cmd_ready  = r_live && (w_count < FULL_CNT);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_push_job = '{mvu: cmd_mvu, desc: cmd_desc};

    job_fifo #(
        .DEPTH (DEPTH),
        .T     (mvu_job_t)
    ) u_job_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_push_data (w_push_job),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign w_head_onehot = mvu_onehot(w_head.mvu);
    assign w_pop         = (r_state == ISSUE);
    assign w_issue_set   = w_pop ? w_head_onehot : '0;
    assign w_done_ok     = mvu_done & r_busy;
    assign w_done_bad    = mvu_done & ~r_busy;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if ((w_count != '0) && !r_busy[w_head.mvu]) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
        end
    end

    // Start/descriptor are registered alongside the IDLE->ISSUE step so they are
    // live for exactly the ISSUE cycle; the head cannot move until that cycle ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= '0;
            r_desc  <= '0;
        end else if (w_state_next == ISSUE) begin
            r_start <= w_head_onehot;
            r_desc  <= w_head.desc;
        end else begin
            r_start <= '0;
            r_desc  <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_irq  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_done_ok) | w_issue_set;
            r_irq  <= (r_irq & ~irq_clr) | w_done_ok;
            if (w_done_bad != '0) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mvu_start = r_start;
    assign mvu_desc  = r_desc;
    assign busy      = r_busy;
    assign mvu_irq   = r_irq;
    assign err       = r_err;
    assign q_count   = w_count;

    // A start names at most one MVU and never one that still holds a job.
    assert property (@(posedge clk) disable iff (rst) $onehot0(mvu_start));
    assert property (@(posedge clk) disable iff (rst) ((mvu_start & busy) == '0));

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// Self-checking bench for mvu_job_dispatcher: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_mvu_job_dispatcher;

    localparam int NUM_MVU = 8;
    localparam int DEPTH   = 4;
    localparam int DESC_W  = 64;

    typedef struct packed {
        logic [2:0]  mvu;
        logic [63:0] desc;
    } tb_job_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_mvu;
    logic [63:0] cmd_desc;
    logic [7:0]  mvu_start;
    logic [63:0] mvu_desc;
    logic [7:0]  mvu_done;
    logic [7:0]  mvu_irq;
    logic [7:0]  irq_clr;
    logic [7:0]  busy;
    logic [2:0]  q_count;
    logic        err;

    int checks = 0;
    int errors = 0;

    tb_job_t     mq[$];
    logic [7:0]  m_start;
    logic [63:0] m_desc;
    logic [7:0]  m_busy;
    logic [7:0]  m_irq;
    logic        m_err;

    mvu_job_dispatcher #(
        .NUM_MVU (NUM_MVU),
        .DEPTH   (DEPTH),
        .DESC_W  (DESC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mvu   (cmd_mvu),
        .cmd_desc  (cmd_desc),
        .mvu_start (mvu_start),
        .mvu_desc  (mvu_desc),
        .mvu_done  (mvu_done),
        .mvu_irq   (mvu_irq),
        .irq_clr   (irq_clr),
        .busy      (busy),
        .q_count   (q_count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, required $finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        cmd_mvu   = '0;
        cmd_desc  = '0;
        mvu_done  = '0;
        irq_clr   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_one(input logic [2:0] mvu, input logic [63:0] desc);
        cmd_valid = 1'b1;
        cmd_mvu   = mvu;
        cmd_desc  = desc;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Reference: jobs wait in a plain queue; a job to a free MVU is shown one cycle
    // after it reaches the head, retires the cycle after that, and done/irq follow busy.
    task automatic model_step();
        logic [7:0] done_ok;
        logic [7:0] next_busy;
        logic [7:0] next_irq;
        tb_job_t    head;
        bit         accept;
        accept    = cmd_valid && (mq.size() < DEPTH);
        done_ok   = mvu_done & m_busy;
        if ((mvu_done & ~m_busy) != 8'h00) m_err = 1'b1;
        next_busy = m_busy & ~done_ok;
        next_irq  = (m_irq & ~irq_clr) | done_ok;
        if (m_start != 8'h00) begin
            head = mq.pop_front();
            next_busy[head.mvu] = 1'b1;
            m_start = 8'h00;
            m_desc  = '0;
        end else if (mq.size() > 0 && m_busy[mq[0].mvu] == 1'b0) begin
            m_start = 8'h01 << mq[0].mvu;
            m_desc  = mq[0].desc;
        end
        if (accept) mq.push_back('{mvu: cmd_mvu, desc: cmd_desc});
        m_busy = next_busy;
        m_irq  = next_irq;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #3;
        checks++; if (q_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_qcount: got %0d expected 0", q_count); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", cmd_ready); end
        checks++; if (busy !== 8'h00) begin errors++; $display("[TB] FAIL reset_busy: got %h expected 00", busy); end
        checks++; if (mvu_irq !== 8'h00) begin errors++; $display("[TB] FAIL reset_irq: got %h expected 00", mvu_irq); end
        checks++; if (mvu_start !== 8'h00 || mvu_desc !== 64'h0) begin errors++; $display("[TB] FAIL reset_start: got %h/%h expected 00/0", mvu_start, mvu_desc); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_rise: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_single_job();
        do_reset();
        push_one(3'd3, 64'hA5);
        checks++; if (mvu_start !== 8'h00) begin errors++; $display("[TB] FAIL single_no_bypass: got %h expected 00", mvu_start); end
        checks++; if (q_count !== 3'd1) begin errors++; $display("[TB] FAIL single_qcount: got %0d expected 1", q_count); end
        tick();
        checks++; if (mvu_start !== 8'h08) begin errors++; $display("[TB] FAIL single_start: got %h expected 08", mvu_start); end
        checks++; if (mvu_desc !== 64'hA5) begin errors++; $display("[TB] FAIL single_desc: got %h expected a5", mvu_desc); end
        checks++; if (busy !== 8'h00) begin errors++; $display("[TB] FAIL single_busy_issue: got %h expected 00", busy); end
        tick();
        checks++; if (mvu_start !== 8'h00 || mvu_desc !== 64'h0) begin errors++; $display("[TB] FAIL single_pulse_len: got %h/%h expected 00/0", mvu_start, mvu_desc); end
        checks++; if (busy !== 8'h08) begin errors++; $display("[TB] FAIL single_busy: got %h expected 08", busy); end
        checks++; if (q_count !== 3'd0) begin errors++; $display("[TB] FAIL single_pop: got %0d expected 0", q_count); end
        mvu_done = 8'h08;
        tick();
        mvu_done = 8'h00;
        checks++; if (busy !== 8'h00) begin errors++; $display("[TB] FAIL single_done_busy: got %h expected 00", busy); end
        checks++; if (mvu_irq !== 8'h08) begin errors++; $display("[TB] FAIL single_done_irq: got %h expected 08", mvu_irq); end
        irq_clr = 8'h08;
        tick();
        irq_clr = 8'h00;
        checks++; if (mvu_irq !== 8'h00) begin errors++; $display("[TB] FAIL single_irq_clr: got %h expected 00", mvu_irq); end
    endtask

    task automatic test_back_to_back();
        int accepted;
        int seen;
        int last;
        do_reset();
        push_one(3'd0, 64'h100);
        tick();
        tick();
        checks++; if (busy !== 8'h01) begin errors++; $display("[TB] FAIL b2b_prime_busy: got %h expected 01", busy); end
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            cmd_valid = (accepted < 5) && cmd_ready;
            cmd_mvu   = 3'(accepted);
            cmd_desc  = 64'hD0 + 64'(accepted);
            tick();
            if (cmd_valid) accepted++;
        end
        cmd_valid = 1'b0;
        checks++; if (accepted !== 4) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d expected 4", accepted); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_ready: got %b expected 0", cmd_ready); end
        checks++; if (q_count !== 3'd4) begin errors++; $display("[TB] FAIL b2b_full_count: got %0d expected 4", q_count); end
        mvu_done = 8'h01;
        tick();
        mvu_done = 8'h00;
        seen = 0;
        last = -100;
        for (int c = 0; c < 20; c++) begin
            cmd_valid = (accepted < 5) && cmd_ready;
            cmd_mvu   = 3'(accepted);
            cmd_desc  = 64'hD0 + 64'(accepted);
            tick();
            if (cmd_valid) accepted++;
            if (mvu_start !== 8'h00) begin
                checks++;
                if (mvu_start !== (8'h01 << seen) || mvu_desc !== 64'hD0 + 64'(seen)) begin
                    errors++; $display("[TB] FAIL b2b_order: start %0d got %h/%h expected %h/%h", seen, mvu_start, mvu_desc, 8'h01 << seen, 64'hD0 + 64'(seen));
                end
                checks++;
                if ((seen == 0 && c != 0) || (seen > 0 && c - last != 2)) begin
                    errors++; $display("[TB] FAIL b2b_spacing: start %0d at step %0d, previous %0d, required spacing 2", seen, c, last);
                end
                last = c;
                seen++;
            end
        end
        cmd_valid = 1'b0;
        checks++; if (seen !== 5) begin errors++; $display("[TB] FAIL b2b_start_count: got %0d expected 5", seen); end
    endtask

    task automatic test_head_block();
        int extra;
        do_reset();
        push_one(3'd2, 64'h21);
        push_one(3'd2, 64'h22);
        checks++; if (mvu_start !== 8'h04 || mvu_desc !== 64'h21) begin errors++; $display("[TB] FAIL block_first: got %h/%h expected 04/21", mvu_start, mvu_desc); end
        push_one(3'd5, 64'h55);
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mvu_start !== 8'h00) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL block_stall: got %0d starts expected 0", extra); end
        checks++; if (busy !== 8'h04 || q_count !== 3'd2) begin errors++; $display("[TB] FAIL block_state: got busy %h count %0d expected 04/2", busy, q_count); end
        mvu_done = 8'h04;
        tick();
        mvu_done = 8'h00;
        checks++; if (mvu_start !== 8'h00 || busy !== 8'h00 || mvu_irq !== 8'h04) begin errors++; $display("[TB] FAIL block_done: got start %h busy %h irq %h expected 00/00/04", mvu_start, busy, mvu_irq); end
        tick();
        checks++; if (mvu_start !== 8'h04 || mvu_desc !== 64'h22) begin errors++; $display("[TB] FAIL block_second: got %h/%h expected 04/22", mvu_start, mvu_desc); end
        tick();
        checks++; if (mvu_start !== 8'h00) begin errors++; $display("[TB] FAIL block_gap: got %h expected 00", mvu_start); end
        tick();
        checks++; if (mvu_start !== 8'h20 || mvu_desc !== 64'h55) begin errors++; $display("[TB] FAIL block_third: got %h/%h expected 20/55", mvu_start, mvu_desc); end
        tick();
        checks++; if (busy !== 8'h24 || q_count !== 3'd0) begin errors++; $display("[TB] FAIL block_final: got busy %h count %0d expected 24/0", busy, q_count); end
    endtask

    task automatic test_err_irq();
        do_reset();
        push_one(3'd1, 64'h11);
        tick();
        tick();
        checks++; if (busy !== 8'h02) begin errors++; $display("[TB] FAIL errirq_busy: got %h expected 02", busy); end
        mvu_done = 8'h40;
        tick();
        mvu_done = 8'h00;
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL errirq_spurious_err: got %b expected 1", err); end
        checks++; if (mvu_irq !== 8'h00 || busy !== 8'h02) begin errors++; $display("[TB] FAIL errirq_spurious_side: got irq %h busy %h expected 00/02", mvu_irq, busy); end
        mvu_done = 8'h02;
        irq_clr  = 8'h02;
        tick();
        mvu_done = 8'h00;
        irq_clr  = 8'h00;
        checks++; if (mvu_irq !== 8'h02 || busy !== 8'h00) begin errors++; $display("[TB] FAIL errirq_set_wins: got irq %h busy %h expected 02/00", mvu_irq, busy); end
        tick();
        checks++; if (mvu_irq !== 8'h02) begin errors++; $display("[TB] FAIL errirq_sticky: got %h expected 02", mvu_irq); end
        irq_clr = 8'h02;
        tick();
        irq_clr = 8'h00;
        checks++; if (mvu_irq !== 8'h00) begin errors++; $display("[TB] FAIL errirq_clear: got %h expected 00", mvu_irq); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL errirq_err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_reset_mid_issue();
        int extra;
        do_reset();
        push_one(3'd0, 64'h30);
        tick();
        tick();
        for (int i = 0; i < 3; i++) push_one(3'(i), 64'h40 + 64'(i));
        checks++; if (q_count !== 3'd3) begin errors++; $display("[TB] FAIL rstmid_queued: got %0d expected 3", q_count); end
        mvu_done = 8'h01;
        tick();
        mvu_done = 8'h00;
        tick();
        checks++; if (mvu_start !== 8'h01 || mvu_desc !== 64'h40) begin errors++; $display("[TB] FAIL rstmid_issue: got %h/%h expected 01/40", mvu_start, mvu_desc); end
        rst = 1'b1;
        #1;
        checks++; if (mvu_start !== 8'h00 || mvu_desc !== 64'h0) begin errors++; $display("[TB] FAIL rstmid_start_drop: got %h/%h expected 00/0", mvu_start, mvu_desc); end
        checks++; if (q_count !== 3'd0 || busy !== 8'h00 || mvu_irq !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_clear: got count %0d busy %h irq %h expected 0/00/00", q_count, busy, mvu_irq); end
        tick();
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (mvu_start !== 8'h00) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL rstmid_no_start: got %0d starts expected 0", extra); end
        checks++; if (cmd_ready !== 1'b1 || q_count !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_after: got ready %b count %0d expected 1/0", cmd_ready, q_count); end
    endtask

    task automatic test_random();
        do_reset();
        mq.delete();
        m_start = '0;
        m_desc  = '0;
        m_busy  = '0;
        m_irq   = '0;
        m_err   = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_mvu   = 3'($urandom_range(0, 7));
            cmd_desc  = {$urandom(), $urandom()};
            mvu_done  = 8'h00;
            for (int i = 0; i < NUM_MVU; i++) begin
                if (m_busy[i] && $urandom_range(0, 3) == 0) mvu_done[i] = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) mvu_done[$urandom_range(0, 7)] = 1'b1;
            irq_clr = 8'($urandom()) & 8'($urandom()) & 8'($urandom());
            tick();
            model_step();
            checks++; if (mvu_start !== m_start) begin errors++; $display("[TB] FAIL rand_start step %0d: got %h expected %h", c, mvu_start, m_start); end
            checks++; if (mvu_desc !== m_desc) begin errors++; $display("[TB] FAIL rand_desc step %0d: got %h expected %h", c, mvu_desc, m_desc); end
            checks++; if (busy !== m_busy) begin errors++; $display("[TB] FAIL rand_busy step %0d: got %h expected %h", c, busy, m_busy); end
            checks++; if (mvu_irq !== m_irq) begin errors++; $display("[TB] FAIL rand_irq step %0d: got %h expected %h", c, mvu_irq, m_irq); end
            checks++; if (err !== m_err) begin errors++; $display("[TB] FAIL rand_err step %0d: got %b expected %b", c, err, m_err); end
            checks++; if (q_count !== 3'(mq.size())) begin errors++; $display("[TB] FAIL rand_qcount step %0d: got %0d expected %0d", c, q_count, mq.size()); end
            checks++; if (cmd_ready !== (mq.size() < DEPTH)) begin errors++; $display("[TB] FAIL rand_ready step %0d: got %b expected %b", c, cmd_ready, mq.size() < DEPTH); end
            checks++; if ((mvu_start & busy) !== 8'h00) begin errors++; $display("[TB] FAIL rand_double_job step %0d: start %h busy %h required no overlap", c, mvu_start, busy); end
            checks++; if (q_count > 3'd4) begin errors++; $display("[TB] FAIL rand_qrange step %0d: got %0d required 0..4", c, q_count); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_back_to_back();
        test_head_block();
        test_err_irq();
        test_reset_mid_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
